muldiv_hilo_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair. It sits in the EX stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo requests from the decoded control bus and runs a 32-iteration shift-add / restoring-divide datapath. It stalls the pipeline while iterating and commits results to HI/LO, which feed mfhi/mflo.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 40 ++++
 rtl/muldiv_hilo_ctrl_if.sv | 31 +++
 rtl/muldiv_hilo_ctrl_md_iter_core.sv | 67 ++++++
 rtl/muldiv_hilo_ctrl.sv | 158 +++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encoding, default widths and small op-decode helpers.
package hilo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // True for the four ops that need the iterative datapath.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the ops whose operands are two's-complement.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // True for the divide flavours.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage control bus between the pipeline and the HI/LO sequencer.
//
// Handshake: the pipeline asserts req with op/src_a/src_b and must hold all
// three stable for every cycle in which stall is high; the request is
// consumed on the first rising edge where stall is low. flush overrides and
// discards whatever is presented or in flight.
interface muldiv_hilo_ctrl_if
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             req;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output req, op, src_a, src_b, flush,
        input  stall, busy, hi, lo
    );

    modport slave (
        input  req, op, src_a, src_b, flush,
        output stall, busy, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_ctrl_md_iter_core.sv
// Combinational datapath for the multiply/divide sequencer: one shift-add
// (multiply) or restoring-divide step per call, plus the final sign fix-up
// that turns magnitude results into signed HI/LO values.
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,      // product upper half / partial remainder
    input  logic [WIDTH-1:0] mq,       // multiplier-product lower half / quotient
    input  logic [WIDTH-1:0] opnd,     // multiplicand or divisor magnitude
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt,
    input  logic             neg_prod,
    input  logic             neg_quo,
    input  logic             neg_rem,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;

    // One iteration: multiply adds into the top half then shifts right;
    // divide shifts {rem,quo} left and keeps the trial difference if it fits.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, opnd};
        shifted = {acc, mq[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        acc_nxt = acc;
        mq_nxt  = mq;
        if (is_div) begin
            if (shifted >= {1'b0, opnd}) begin
                acc_nxt = diff[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b0};
            end
        end else if (mq[0]) begin
            acc_nxt = sum[WIDTH:1];
            mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[WIDTH-1:1]};
            mq_nxt  = {acc[0], mq[WIDTH-1:1]};
        end
    end

    // Sign fix-up: negate the full product, or the quotient and remainder
    // independently. Divide-by-zero arrives with neg_quo clear, so the
    // all-ones quotient survives and the remainder regains the dividend sign.
    always_comb begin
        prod = {acc, mq};
        if (neg_prod) begin
            prod = -prod;
        end
        if (is_div) begin
            hi_res = neg_rem ? -acc : acc;
            lo_res = neg_quo ? -mq  : mq;
        end else begin
            hi_res = prod[2*WIDTH-1:WIDTH];
            lo_res = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO multiply/divide sequencer. Owns the HI/LO pair, runs a WIDTH-step
// iterative multiply or divide through md_iter_core, stalls the pipeline
// while iterating and commits the result in the FIX cycle. mthi/mtlo write
// directly from IDLE without stalling. CNT_W must satisfy 2**CNT_W == WIDTH.
module muldiv_hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    muldiv_hilo_ctrl_if.slave      bus,
    output md_state_t              dbg_state
);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_prod;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mq_nxt;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;

    logic             launch;
    logic             last_iter;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .is_div   (is_div),
        .acc      (acc),
        .mq       (mq),
        .opnd     (opnd),
        .acc_nxt  (acc_nxt),
        .mq_nxt   (mq_nxt),
        .neg_prod (neg_prod),
        .neg_quo  (neg_quo),
        .neg_rem  (neg_rem),
        .hi_res   (hi_res),
        .lo_res   (lo_res)
    );

    // Operand conditioning: magnitudes for signed ops, raw values otherwise.
    always_comb begin
        sgn    = is_signed_op(bus.op);
        a_neg  = sgn & bus.src_a[WIDTH-1];
        b_neg  = sgn & bus.src_b[WIDTH-1];
        a_abs  = a_neg ? -bus.src_a : bus.src_a;
        b_abs  = b_neg ? -bus.src_b : bus.src_b;
        launch = (state == IDLE) & bus.req & is_md_op(bus.op) & ~bus.flush;
        last_iter = (cnt == {CNT_W{1'b1}});
    end

    // FSM next state and stall; flush forces IDLE from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch)    state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = FIX;
            FIX:                    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
        end
        bus.stall = ~bus.flush &
                    (((state == IDLE) & bus.req & is_md_op(bus.op)) |
                     (state == RUN));
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
        end
    end

    // Iteration counter and datapath registers: loaded at launch, stepped in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_prod <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (launch) begin
            cnt      <= '0;
            acc      <= '0;
            is_div   <= is_div_op(bus.op);
            if (is_div_op(bus.op)) begin
                mq       <= a_abs;
                opnd     <= b_abs;
                neg_prod <= 1'b0;
                neg_quo  <= (a_neg ^ b_neg) & (bus.src_b != '0);
                neg_rem  <= a_neg;
            end else begin
                mq       <= b_abs;
                opnd     <= a_abs;
                neg_prod <= a_neg ^ b_neg;
                neg_quo  <= 1'b0;
                neg_rem  <= 1'b0;
            end
        end else if ((state == RUN) && !bus.flush) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
            mq  <= mq_nxt;
        end
    end

    // HI/LO: direct moves from IDLE, result commit in FIX; flush blocks both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!bus.flush) begin
            if ((state == IDLE) && bus.req && (bus.op == MD_MTHI)) begin
                hi_q <= bus.src_a;
            end else if ((state == IDLE) && bus.req && (bus.op == MD_MTLO)) begin
                lo_q <= bus.src_a;
            end else if (state == FIX) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: reset values, each mult/div flavour,
// divide corner cases, mthi/mtlo, back-to-back issue, flush and mid-run reset.
module tb_muldiv_hilo_ctrl;
    import hilo_pkg::*;

    logic      clk;
    logic      rst_n;
    md_state_t dbg_state;
    int        vectors;
    int        miscompares;

    muldiv_hilo_ctrl_if #(.WIDTH(32)) bus_if ();

    muldiv_hilo_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a mult/div in the current cycle, counts stall cycles (bounded),
    // and returns 1 time unit after the edge that ends the FIX cycle.
    task automatic issue_md(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input string nm);
        int n;
        bus_if.req   = 1'b1;
        bus_if.op    = o;
        bus_if.src_a = a;
        bus_if.src_b = b;
        n = 0;
        @(negedge clk);
        while (bus_if.stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== 33) begin
            miscompares++;
            $display("FAIL %s stall_cycles got %0d want 33", nm, n);
        end
        vectors++;
        if (dbg_state !== FIX || bus_if.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s fix_state got state=%0d busy=%b want state=%0d busy=1",
                     nm, dbg_state, bus_if.busy, FIX);
        end
        next_cycle();
    endtask

    // Full single operation: issue, release, check result and idle.
    task automatic test_md(input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh,
                           input logic [31:0] el, input string nm);
        issue_md(o, a, b, nm);
        bus_if.req = 1'b0;
        bus_if.op  = MD_NONE;
        @(negedge clk);
        vectors++;
        if (bus_if.hi !== eh || bus_if.lo !== el) begin
            miscompares++;
            $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h",
                     nm, bus_if.hi, bus_if.lo, eh, el);
        end
        vectors++;
        if (bus_if.busy !== 1'b0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL %s idle_after got busy=%b state=%0d want 0/%0d",
                     nm, bus_if.busy, dbg_state, IDLE);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus_if.req    = 1'b0;
        bus_if.op     = MD_NONE;
        bus_if.src_a  = '0;
        bus_if.src_b  = '0;
        bus_if.flush  = 1'b0;
        #2;
        vectors++;
        if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0 || bus_if.busy !== 1'b0 ||
            bus_if.stall !== 1'b0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_values got hi=%h lo=%h busy=%b stall=%b state=%0d want 0/0/0/0/%0d",
                     bus_if.hi, bus_if.lo, bus_if.busy, bus_if.stall, dbg_state, IDLE);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    // mthi/mtlo: no stall, visible the next cycle.
    task automatic test_move(input logic [2:0] o, input logic [31:0] v,
                             input string nm);
        bus_if.req   = 1'b1;
        bus_if.op    = o;
        bus_if.src_a = v;
        @(negedge clk);
        vectors++;
        if (bus_if.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL %s stall got %b want 0", nm, bus_if.stall);
        end
        next_cycle();
        bus_if.req = 1'b0;
        bus_if.op  = MD_NONE;
        @(negedge clk);
        vectors++;
        if (((o == MD_MTHI) ? bus_if.hi : bus_if.lo) !== v) begin
            miscompares++;
            $display("FAIL %s value got hi=%h lo=%h want %h", nm, bus_if.hi, bus_if.lo, v);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        issue_md(MD_MULTU, 32'd7, 32'd6, "b2b_first");
        vectors++;
        if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h2A) begin
            miscompares++;
            $display("FAIL b2b_first result got hi=%h lo=%h want hi=00000000 lo=0000002a",
                     bus_if.hi, bus_if.lo);
        end
        test_md(MD_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, "b2b_second");
    endtask

    task automatic test_flush();
        test_move(MD_MTHI, 32'hAAAA_0001, "flush_prep_hi");
        test_move(MD_MTLO, 32'h5555_0002, "flush_prep_lo");
        // MTLO presented together with flush is dropped.
        bus_if.req   = 1'b1;
        bus_if.op    = MD_MTLO;
        bus_if.src_a = 32'hDEAD_BEEF;
        bus_if.flush = 1'b1;
        next_cycle();
        bus_if.req   = 1'b0;
        bus_if.flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_if.lo !== 32'h5555_0002) begin
            miscompares++;
            $display("FAIL flush_mtlo lo got %h want 55550002", bus_if.lo);
        end
        next_cycle();
        // MULT launched in cycle 0, flushed in cycle 10.
        bus_if.req   = 1'b1;
        bus_if.op    = MD_MULT;
        bus_if.src_a = 32'd3;
        bus_if.src_b = 32'd3;
        repeat (10) next_cycle();
        bus_if.flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_if.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_stall got %b want 0", bus_if.stall);
        end
        next_cycle();
        bus_if.flush = 1'b0;
        bus_if.req   = 1'b0;
        bus_if.op    = MD_NONE;
        @(negedge clk);
        vectors++;
        if (dbg_state !== IDLE || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle got state=%0d busy=%b want %0d/0",
                     dbg_state, bus_if.busy, IDLE);
        end
        vectors++;
        if (bus_if.hi !== 32'hAAAA_0001 || bus_if.lo !== 32'h5555_0002) begin
            miscompares++;
            $display("FAIL flush_keep got hi=%h lo=%h want aaaa0001/55550002",
                     bus_if.hi, bus_if.lo);
        end
        next_cycle();
        test_md(MD_DIVU, 32'd1000, 32'd3, 32'h1, 32'h14D, "flush_then_divu");
    endtask

    task automatic test_reset_mid_run();
        test_move(MD_MTHI, 32'h1234, "rst_prep_hi");
        bus_if.req   = 1'b1;
        bus_if.op    = MD_MULT;
        bus_if.src_a = 32'd9;
        bus_if.src_b = 32'd9;
        repeat (15) next_cycle();
        rst_n      = 1'b0;
        bus_if.req = 1'b0;
        bus_if.op  = MD_NONE;
        #1;
        vectors++;
        if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0 || bus_if.busy !== 1'b0 ||
            bus_if.stall !== 1'b0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_mid_run got hi=%h lo=%h busy=%b stall=%b state=%0d want 0/0/0/0/%0d",
                     bus_if.hi, bus_if.lo, bus_if.busy, bus_if.stall, dbg_state, IDLE);
        end
        next_cycle();
        rst_n = 1'b1;
        repeat (40) next_cycle();
        @(negedge clk);
        vectors++;
        if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_no_write got hi=%h lo=%h state=%0d want 0/0/%0d",
                     bus_if.hi, bus_if.lo, dbg_state, IDLE);
        end
        next_cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_move(MD_MTHI, 32'h0000_1234, "mthi");
        test_move(MD_MTLO, 32'h0000_5678, "mtlo");
        test_md(MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
        test_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        test_md(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin");
        test_md(MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
        test_md(MD_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, "divu_100by7");
        test_md(MD_DIV,   32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, "div_5by0");
        test_md(MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg5by0");
        test_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_by_m1");
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
